// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative multiply/divide sequencer:
//   muldiv_op_t     - operation code as delivered by the decoder
//   muldiv_state_t  - sequencer FSM states
//   MULDIV_WIDTH    - operand width
//   DIV0_QUOTIENT   - quotient written on divide by zero
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [MULDIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // True for the two divide encodings.
  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // True for the two signed encodings.
  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// ---------------------------------------------------------------------------
// muldiv_signfix
// Purely combinational two's-complement sign correction.
//   raw    in  64 : unsigned result (or two 32-bit operands)
//   wide   in  1  : 1 = treat raw as one 64-bit value negated by neg_hi,
//                   0 = treat the halves independently
//   neg_hi in  1  : negate the 64-bit value (wide) or the upper half
//   neg_lo in  1  : negate the lower half (split mode only)
//   hi     out 32 : corrected upper half
//   lo     out 32 : corrected lower half
// Split mode doubles as the operand-magnitude helper (abs of rs and rt).
// ---------------------------------------------------------------------------
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [2*MULDIV_WIDTH-1:0] raw,
  input  logic                      wide,
  input  logic                      neg_hi,
  input  logic                      neg_lo,
  output logic [MULDIV_WIDTH-1:0]   hi,
  output logic [MULDIV_WIDTH-1:0]   lo
);

  logic [2*MULDIV_WIDTH-1:0] neg_wide_s;

  function automatic logic [MULDIV_WIDTH-1:0] negate32(input logic [MULDIV_WIDTH-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Select raw or negated value per half (split) or as a whole (wide).
  always_comb begin
    neg_wide_s = ~raw + 64'd1;
    hi         = raw[2*MULDIV_WIDTH-1:MULDIV_WIDTH];
    lo         = raw[MULDIV_WIDTH-1:0];
    if (wide) begin
      if (neg_hi) begin
        {hi, lo} = neg_wide_s;
      end else begin
        {hi, lo} = raw;
      end
    end else begin
      if (neg_hi) begin
        hi = negate32(raw[2*MULDIV_WIDTH-1:MULDIV_WIDTH]);
      end else begin
        hi = raw[2*MULDIV_WIDTH-1:MULDIV_WIDTH];
      end
      if (neg_lo) begin
        lo = negate32(raw[MULDIV_WIDTH-1:0]);
      end else begin
        lo = raw[MULDIV_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO write port.
// Shift-add multiply / restoring divide over ITERATIONS cycles on operand
// magnitudes, followed by one DONE cycle that presents the sign-corrected
// result and pulses hiLoWrite.
//   clk       in  1  : clock, rising edge
//   reset     in  1  : synchronous active-high reset to IDLE
//   start     in  1  : request strobe, honoured only in IDLE
//   op        in  2  : MULT=0, MULTU=1, DIV=2, DIVU=3
//   rs        in  32 : multiplicand / dividend
//   rt        in  32 : multiplier / divisor
//   busy      out 1  : state is not IDLE (core stall)
//   hiLoWrite out 1  : one-cycle HI/LO write enable
//   hiOut     out 32 : HI result (product high / remainder)
//   loOut     out 32 : LO result (product low / quotient)
//   done      out 1  : copy of hiLoWrite
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        hiLoWrite,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        done
);

  import muldiv_pkg::*;

  localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  // FSM and counter
  muldiv_state_t    state_r;
  muldiv_state_t    next_state_s;
  logic [CNT_W-1:0] cnt_r;

  // Latched request
  muldiv_op_t       op_r;
  logic             sign_hi_r;   // product sign (mul) / remainder sign (div)
  logic             sign_lo_r;   // product sign (mul) / quotient sign (div)

  // Working registers: mul {acc_hi, acc_lo}, div {rem, quot}
  logic [32:0]      work_hi_r;
  logic [31:0]      work_lo_r;
  logic [31:0]      mcand_r;     // multiplicand or divisor magnitude

  // Registered outputs
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             busy_r;
  logic             write_r;

  // Request decode
  muldiv_op_t       op_in_s;
  logic             in_div_s;
  logic             in_signed_s;
  logic             div_zero_s;
  logic             accept_s;
  logic             last_iter_s;
  logic [31:0]      rs_mag_s;
  logic [31:0]      rt_mag_s;

  // Iteration datapath
  logic [31:0]      addend_s;
  logic [32:0]      sum_s;
  logic [33:0]      rem_sh_s;
  logic             trial_ok_s;
  logic [32:0]      rem_diff_s;
  logic [32:0]      work_hi_nxt_s;
  logic [31:0]      work_lo_nxt_s;
  logic [31:0]      fix_hi_s;
  logic [31:0]      fix_lo_s;

  // Output decode
  logic             busy_s;
  logic             write_s;

  assign op_in_s     = muldiv_op_t'(op);
  assign in_div_s    = op_is_div(op_in_s);
  assign in_signed_s = op_is_signed(op_in_s);
  assign div_zero_s  = in_div_s && (rt == 32'd0);
  assign accept_s    = (state_r == IDLE) && start;
  assign last_iter_s = (cnt_r == CNT_W'(ITERATIONS - 1));

  // Operand magnitudes: abs() for signed ops, raw value for unsigned ones.
  muldiv_signfix u_operand_mag (
    .raw    ({rs, rt}),
    .wide   (1'b0),
    .neg_hi (in_signed_s & rs[31]),
    .neg_lo (in_signed_s & rt[31]),
    .hi     (rs_mag_s),
    .lo     (rt_mag_s)
  );

  // One multiply step and one restoring-divide step, selected by op_r.
  always_comb begin
    // Multiply: conditional add into acc_hi, then shift the 65-bit
    // {carry, acc_hi, acc_lo} right by one.
    addend_s = work_lo_r[0] ? mcand_r : 32'd0;
    sum_s    = {1'b0, work_hi_r[31:0]} + {1'b0, addend_s};

    // Divide: shift {rem, quot} left, trial-subtract the divisor. The
    // shifted remainder is kept at 34 bits so the compare sees every bit.
    rem_sh_s   = {work_hi_r, work_lo_r[31]};
    trial_ok_s = (rem_sh_s >= {2'b00, mcand_r});
    rem_diff_s = rem_sh_s[32:0] - {1'b0, mcand_r};

    if (op_is_div(op_r)) begin
      work_hi_nxt_s = trial_ok_s ? rem_diff_s : rem_sh_s[32:0];
      work_lo_nxt_s = {work_lo_r[30:0], trial_ok_s};
    end else begin
      work_hi_nxt_s = {1'b0, sum_s[32:1]};
      work_lo_nxt_s = {sum_s[0], work_lo_r[31:1]};
    end
  end

  // Sign correction of the value produced by the final iteration; both
  // modes share the {hi, lo} layout so one corrector serves both.
  muldiv_signfix u_result_fix (
    .raw    ({work_hi_nxt_s[31:0], work_lo_nxt_s}),
    .wide   (~op_is_div(op_r)),
    .neg_hi (sign_hi_r),
    .neg_lo (sign_lo_r),
    .hi     (fix_hi_s),
    .lo     (fix_lo_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = div_zero_s ? DONE : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM output decode, taken from the next state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    busy_s  = 1'b0;
    write_s = 1'b0;
    case (next_state_s)
      IDLE: begin
        busy_s  = 1'b0;
        write_s = 1'b0;
      end
      RUN: begin
        busy_s  = 1'b1;
        write_s = 1'b0;
      end
      DONE: begin
        busy_s  = 1'b1;
        write_s = 1'b1;
      end
      default: begin
        busy_s  = 1'b0;
        write_s = 1'b0;
      end
    endcase
  end

  // Output flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r  <= 1'b0;
      write_r <= 1'b0;
    end else begin
      busy_r  <= busy_s;
      write_r <= write_s;
    end
  end

  // Request latch, iteration registers, counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= MULT;
      sign_hi_r <= 1'b0;
      sign_lo_r <= 1'b0;
      work_hi_r <= 33'd0;
      work_lo_r <= 32'd0;
      mcand_r   <= 32'd0;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else if (accept_s) begin
      op_r      <= op_in_s;
      cnt_r     <= {CNT_W{1'b0}};
      work_hi_r <= 33'd0;
      if (in_div_s) begin
        work_lo_r <= rs_mag_s;
        mcand_r   <= rt_mag_s;
        sign_hi_r <= in_signed_s & rs[31];
        sign_lo_r <= in_signed_s & (rs[31] ^ rt[31]);
      end else begin
        work_lo_r <= rt_mag_s;
        mcand_r   <= rs_mag_s;
        sign_hi_r <= in_signed_s & (rs[31] ^ rt[31]);
        sign_lo_r <= in_signed_s & (rs[31] ^ rt[31]);
      end
      // Divide by zero skips RUN, so its result is loaded right here.
      if (div_zero_s) begin
        hi_r <= rs;
        lo_r <= DIV0_QUOTIENT;
      end
    end else if (state_r == RUN) begin
      cnt_r     <= cnt_r + CNT_W'(1);
      work_hi_r <= work_hi_nxt_s;
      work_lo_r <= work_lo_nxt_s;
      if (last_iter_s) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end
    end
  end

  assign busy      = busy_r;
  assign hiLoWrite = write_r;
  assign done      = write_r;
  assign hiOut     = hi_r;
  assign loOut     = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed bench for muldiv_sequencer: expected HI/LO values and write
// latency are queued when a request is issued and compared when the
// hiLoWrite pulse arrives. Covers reset values, signed/unsigned multiply
// and divide, divide by zero, signed overflow, ignored start, reset
// during RUN, reset together with start, and back-to-back acceptance.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy;
  logic        hiLoWrite;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        done;

  muldiv_sequencer #(.ITERATIONS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .busy      (busy),
    .hiLoWrite (hiLoWrite),
    .hiOut     (hiOut),
    .loOut     (loOut),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current cycle (cycle 0); returns mid-cycle 1
  // with the operand inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input bit push);
    exp_t e;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.lat = lat;
      sb_q.push_back(e);
    end
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(3, 0));
    rs    = $urandom;
    rt    = $urandom;
  endtask

  // Wait (bounded) for the write pulse, starting mid-cycle first_cyc, and
  // compare it against the oldest scoreboard entry.
  task automatic wait_result(input string tag, input int first_cyc);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = first_cyc;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (hiLoWrite === 1'b1) begin
        seen = 1'b1;
      end else begin
        check({tag, " busy"}, {63'd0, busy}, 64'd1);
        @(negedge clk);
        cyc = cyc + 1;
      end
    end
    check({tag, " write seen"}, {63'd0, seen}, 64'd1);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " latency"}, 64'(cyc), 64'(e.lat));
      check({tag, " hiOut"}, {32'd0, hiOut}, {32'd0, e.hi});
      check({tag, " loOut"}, {32'd0, loOut}, {32'd0, e.lo});
      check({tag, " done"}, {63'd0, done}, 64'd1);
      check({tag, " busy at write"}, {63'd0, busy}, 64'd1);
      @(negedge clk);
      check({tag, " busy after"}, {63'd0, busy}, 64'd0);
      check({tag, " write after"}, {63'd0, hiLoWrite}, 64'd0);
      check({tag, " hi hold"}, {32'd0, hiOut}, {32'd0, e.hi});
      check({tag, " lo hold"}, {32'd0, loOut}, {32'd0, e.lo});
    end else if (sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int pulses;

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hiLoWrite", {63'd0, hiLoWrite}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hiOut", {32'd0, hiOut}, 64'd0);
    check("reset loOut", {32'd0, loOut}, 64'd0);

    // Multiply cases
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b1);
    wait_result("multu max", 1);
    issue(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b1);
    wait_result("mult neg*pos", 1);
    issue(MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, 33, 1'b1);
    wait_result("mult neg*neg", 1);

    // Divide cases
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b1);
    wait_result("div -7/2", 1);
    issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 1'b1);
    wait_result("div 7/-2", 1);
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
    wait_result("divu 100/7", 1);
    issue(DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1, 1'b1);
    wait_result("divu by zero", 1);
    issue(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 1'b1);
    wait_result("div by zero", 1);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b1);
    wait_result("div overflow", 1);

    // Second start in cycle 5 must be ignored
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    rs    = 32'd100;
    rt    = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_result("start ignored", 6);

    // Reset in cycle 10 of a multiply
    issue(MULT, 32'd123, 32'd456, 32'd0, 32'd0, 33, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", {63'd0, busy}, 64'd0);
    check("mid reset write", {63'd0, hiLoWrite}, 64'd0);
    check("mid reset hiOut", {32'd0, hiOut}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (hiLoWrite === 1'b1) pulses = pulses + 1;
      @(negedge clk);
    end
    check("mid reset no pulse", 64'(pulses), 64'd0);

    // Reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    op    = DIVU;
    rs    = 32'd1;
    rt    = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset+start busy", {63'd0, busy}, 64'd0);
    check("reset+start write", {63'd0, hiLoWrite}, 64'd0);

    // Recovery
    issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33, 1'b1);
    wait_result("multu 6x7", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
